// File: rtl/control_unit_pkg.sv
// Shared state codes, opcodes and encodings
// for the multicycle control unit.
package control_unit_pkg;

   typedef enum logic [4:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_REGREG,
      S_LUI,
      S_REGIMM,
      S_AUIPC,
      S_JAL,
      S_BRANCH,
      S_JALR,
      S_LOAD,
      S_STORE,
      S_ECALL,
      S_XRET,
      S_ZICSR,
      S_MULDIV,
      S_ILLEGAL
   } state_e;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_IMM32  = 7'b0011011;
   localparam logic [6:0] OP_REG32  = 7'b0111011;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   localparam logic [2:0] WR_ALU = 3'd0;
   localparam logic [2:0] WR_CSR = 3'd1;
   localparam logic [2:0] WR_MEM = 3'd2;
   localparam logic [2:0] WR_PC4 = 3'd3;
   localparam logic [2:0] WR_MUL = 3'd4;

   // Lane mask for an access of 1<<size bytes at offset 0.
   function automatic logic [7:0] lane_mask(
      input logic [1:0] size
   );
      unique case (size)
         2'd0:    lane_mask = 8'h01;
         2'd1:    lane_mask = 8'h03;
         2'd2:    lane_mask = 8'h0F;
         default: lane_mask = 8'hFF;
      endcase
   endfunction

   function automatic logic [2:0] align_mask(
      input logic [1:0] size
   );
      align_mask = {size == 2'd3, size[1], |size};
   endfunction

endpackage

// File: rtl/cu_decoder.sv
// Opcode/funct legality check producing the
// execute state that follows Decode.
module cu_decoder
   import control_unit_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter bit HAS_M     = 1'b0,
   parameter bit HAS_ZICSR = 1'b1,
   parameter bit HAS_XRET  = 1'b1
) (
   input  logic [6:0] opcode_i,
   input  logic [2:0] funct3_i,
   input  logic [6:0] funct7_i,
   output state_e     next_o
);

   localparam bit RV64 = (XLEN == 64);

   logic f7z, f7a, f7m;
   logic shz, sha;
   logic imm_ok, reg_ok, ld_ok, st_ok;
   logic imm32_ok, reg32_ok, mul32_ok;
   logic f3_0, f3_1, f3_5;

   assign f3_0 = (funct3_i == 3'b000);
   assign f3_1 = (funct3_i == 3'b001);
   assign f3_5 = (funct3_i == 3'b101);
   assign f7z  = (funct7_i == 7'b0000000);
   assign f7a  = (funct7_i == 7'b0100000);
   assign f7m  = (funct7_i == 7'b0000001);

   // RV64 shamt is 6 bits, so funct7[0] is shamt[5].
   assign shz = RV64 ? (funct7_i[6:1] == 6'b000000)
                     : f7z;
   assign sha = RV64 ? (funct7_i[6:1] == 6'b010000)
                     : f7a;

   assign imm_ok = f3_1 ? shz :
                   f3_5 ? (shz | sha) : 1'b1;
   assign reg_ok = f7z | (f7a & (f3_0 | f3_5));
   assign ld_ok  = (funct3_i != 3'b111) &&
                   (RV64 || (funct3_i != 3'b011 &&
                             funct3_i != 3'b110));
   assign st_ok  = !funct3_i[2] &&
                   (RV64 || funct3_i[1:0] != 2'b11);

   assign imm32_ok = f3_0 | (f3_1 & f7z) |
                     (f3_5 & (f7z | f7a));
   assign reg32_ok = (f7z & (f3_0 | f3_1 | f3_5)) |
                     (f7a & (f3_0 | f3_5));
   assign mul32_ok = HAS_M & f7m &
                     (f3_0 | funct3_i[2]);

   always_comb begin
      next_o = S_ILLEGAL;
      unique case (opcode_i)
         OP_LUI:   next_o = S_LUI;
         OP_AUIPC: next_o = S_AUIPC;
         OP_JAL:   next_o = S_JAL;
         OP_JALR: begin
            if (f3_0) next_o = S_JALR;
         end
         OP_BRANCH: begin
            if (funct3_i[2:1] != 2'b01)
               next_o = S_BRANCH;
         end
         OP_LOAD: begin
            if (ld_ok) next_o = S_LOAD;
         end
         OP_STORE: begin
            if (st_ok) next_o = S_STORE;
         end
         OP_IMM: begin
            if (imm_ok) next_o = S_REGIMM;
         end
         OP_REG: begin
            if (reg_ok)
               next_o = S_REGREG;
            else if (HAS_M && f7m)
               next_o = S_MULDIV;
         end
         OP_IMM32: begin
            if (RV64 && imm32_ok)
               next_o = S_REGIMM;
         end
         OP_REG32: begin
            if (RV64 && reg32_ok)
               next_o = S_REGREG;
            else if (RV64 && mul32_ok)
               next_o = S_MULDIV;
         end
         OP_SYSTEM: begin
            if (f3_0) begin
               if (f7z)
                  next_o = S_ECALL;
               else if (HAS_XRET &&
                        (funct7_i == 7'b0011000 ||
                         funct7_i == 7'b0001000))
                  next_o = S_XRET;
            end else if (HAS_ZICSR &&
                         funct3_i != 3'b100) begin
               next_o = S_ZICSR;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RISC-V control FSM: state register,
// memory timeout, M-unit handshake, datapath controls.
module multicycle_control_unit
   import control_unit_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter bit HAS_M       = 1'b0,
   parameter bit HAS_ZICSR   = 1'b1,
   parameter bit HAS_XRET    = 1'b1,
   parameter int MEM_TIMEOUT = 256
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              mem_ack,
   output logic              mem_rd_en,
   output logic              mem_wr_en,
   output logic [XLEN/8-1:0] mem_byte_en,
   input  logic [2:0]        mem_addr_low,
   input  logic [6:0]        opcode,
   input  logic [2:0]        funct3,
   input  logic [6:0]        funct7,
   input  logic              zero,
   input  logic              negative,
   input  logic              carry_out,
   input  logic              overflow,
   input  logic [1:0]        privilege_mode,
   input  logic              csr_addr_exception,
   input  logic              muldiv_done,
   output logic              muldiv_start,
   output logic              alua_src,
   output logic              alub_src,
   output logic              aluy_src,
   output logic              alupc_src,
   output logic              sub,
   output logic              arithmetic,
   output logic              pc_src,
   output logic              pc_en,
   output logic              ir_en,
   output logic              mem_addr_src,
   output logic [2:0]        alu_src,
   output logic [2:0]        wr_reg_src,
   output logic              wr_reg_en,
   output logic              csr_imm,
   output logic              csr_wr_en,
   output logic [1:0]        csr_op,
   output logic              mret,
   output logic              sret,
   output logic              ecall,
   output logic              illegal_instruction,
   output logic              load_misaligned,
   output logic              store_misaligned,
   output logic              bus_error
);

   localparam int NB = XLEN / 8;
   localparam int CW = (MEM_TIMEOUT > 1) ?
                       $clog2(MEM_TIMEOUT) : 1;
   localparam logic [CW-1:0] TO_LAST =
      CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

   state_e        state_q, state_d, dec_next;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          start_q, start_d;

   logic          timeout, misaligned, taken, w_op;
   logic [2:0]    off;
   logic [NB-1:0] lanes;

   cu_decoder #(
      .XLEN      (XLEN),
      .HAS_M     (HAS_M),
      .HAS_ZICSR (HAS_ZICSR),
      .HAS_XRET  (HAS_XRET)
   ) u_dec (
      .opcode_i (opcode),
      .funct3_i (funct3),
      .funct7_i (funct7),
      .next_o   (dec_next)
   );

   assign off        = mem_addr_low & 3'(NB - 1);
   assign lanes      = NB'(lane_mask(funct3[1:0])) << off;
   assign misaligned = |(mem_addr_low &
                         align_mask(funct3[1:0]));
   assign timeout    = (MEM_TIMEOUT != 0) &&
                       (cnt_q == TO_LAST) && !mem_ack;
   assign w_op       = (XLEN == 64) &&
                       (opcode == OP_IMM32 ||
                        opcode == OP_REG32);

   always_comb begin
      taken = 1'b0;
      unique case (funct3)
         3'b000:  taken = zero;
         3'b001:  taken = !zero;
         3'b100:  taken = negative ^ overflow;
         3'b101:  taken = !(negative ^ overflow);
         3'b110:  taken = !carry_out;
         3'b111:  taken = carry_out;
         default: taken = 1'b0;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         start_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         start_q <= start_d;
      end
   end

   always_comb begin
      state_d             = state_q;
      cnt_d               = '0;
      start_d             = 1'b0;
      mem_rd_en           = 1'b0;
      mem_wr_en           = 1'b0;
      mem_byte_en         = '0;
      muldiv_start        = 1'b0;
      alua_src            = 1'b0;
      alub_src            = 1'b0;
      aluy_src            = 1'b0;
      alupc_src           = 1'b0;
      sub                 = 1'b0;
      arithmetic          = 1'b0;
      pc_src              = 1'b0;
      pc_en               = 1'b0;
      ir_en               = 1'b0;
      mem_addr_src        = 1'b0;
      alu_src             = 3'b000;
      wr_reg_src          = WR_ALU;
      wr_reg_en           = 1'b0;
      csr_imm             = 1'b0;
      csr_wr_en           = 1'b0;
      csr_op              = 2'b00;
      mret                = 1'b0;
      sret                = 1'b0;
      ecall               = 1'b0;
      illegal_instruction = 1'b0;
      load_misaligned     = 1'b0;
      store_misaligned    = 1'b0;
      bus_error           = 1'b0;
      unique case (state_q)
         S_IDLE: state_d = S_FETCH;
         S_FETCH: begin
            mem_byte_en[3:0] = '1;
            if (mem_ack) begin
               ir_en   = 1'b1;
               state_d = S_DECODE;
            end else if (timeout) begin
               bus_error = 1'b1;
               pc_en     = 1'b1;
               state_d   = S_FETCH;
            end else begin
               mem_rd_en = 1'b1;
               cnt_d     = cnt_q + CW'(1);
            end
         end
         S_DECODE: state_d = dec_next;
         S_REGREG: begin
            alu_src    = funct3;
            aluy_src   = w_op;
            sub        = funct7[5] && funct3 == 3'b000;
            arithmetic = funct7[5] && funct3 == 3'b101;
            wr_reg_en  = 1'b1;
            pc_en      = 1'b1;
            state_d    = S_FETCH;
         end
         S_REGIMM: begin
            alub_src   = 1'b1;
            alu_src    = funct3;
            aluy_src   = w_op;
            arithmetic = funct7[5] && funct3 == 3'b101;
            wr_reg_en  = 1'b1;
            pc_en      = 1'b1;
            state_d    = S_FETCH;
         end
         S_LUI: begin
            alub_src  = 1'b1;
            wr_reg_en = 1'b1;
            pc_en     = 1'b1;
            state_d   = S_FETCH;
         end
         S_AUIPC: begin
            alua_src  = 1'b1;
            alub_src  = 1'b1;
            wr_reg_en = 1'b1;
            pc_en     = 1'b1;
            state_d   = S_FETCH;
         end
         S_JAL: begin
            pc_src     = 1'b1;
            wr_reg_src = WR_PC4;
            wr_reg_en  = 1'b1;
            pc_en      = 1'b1;
            state_d    = S_FETCH;
         end
         S_JALR: begin
            alub_src   = 1'b1;
            alupc_src  = 1'b1;
            pc_src     = 1'b1;
            wr_reg_src = WR_PC4;
            wr_reg_en  = 1'b1;
            pc_en      = 1'b1;
            state_d    = S_FETCH;
         end
         S_BRANCH: begin
            sub     = 1'b1;
            pc_src  = taken;
            pc_en   = 1'b1;
            state_d = S_FETCH;
         end
         S_LOAD: begin
            alub_src     = 1'b1;
            mem_addr_src = 1'b1;
            if (misaligned) begin
               load_misaligned = 1'b1;
               pc_en           = 1'b1;
               state_d         = S_FETCH;
            end else begin
               mem_byte_en = lanes;
               if (mem_ack) begin
                  wr_reg_src = WR_MEM;
                  wr_reg_en  = 1'b1;
                  pc_en      = 1'b1;
                  state_d    = S_FETCH;
               end else if (timeout) begin
                  bus_error = 1'b1;
                  pc_en     = 1'b1;
                  state_d   = S_FETCH;
               end else begin
                  mem_rd_en = 1'b1;
                  cnt_d     = cnt_q + CW'(1);
               end
            end
         end
         S_STORE: begin
            alub_src     = 1'b1;
            mem_addr_src = 1'b1;
            if (misaligned) begin
               store_misaligned = 1'b1;
               pc_en            = 1'b1;
               state_d          = S_FETCH;
            end else begin
               mem_byte_en = lanes;
               if (mem_ack) begin
                  pc_en   = 1'b1;
                  state_d = S_FETCH;
               end else if (timeout) begin
                  bus_error = 1'b1;
                  pc_en     = 1'b1;
                  state_d   = S_FETCH;
               end else begin
                  mem_wr_en = 1'b1;
                  cnt_d     = cnt_q + CW'(1);
               end
            end
         end
         S_ECALL: begin
            ecall   = 1'b1;
            pc_en   = 1'b1;
            state_d = S_FETCH;
         end
         S_XRET: begin
            mret    = funct7[4];
            sret    = !funct7[4];
            pc_en   = 1'b1;
            state_d = S_FETCH;
         end
         S_ZICSR: begin
            // csr_addr[9:8] is the minimum privilege.
            if (privilege_mode < funct7[4:3]) begin
               state_d = S_ILLEGAL;
            end else begin
               csr_wr_en           = 1'b1;
               csr_op              = funct3[1:0];
               csr_imm             = funct3[2];
               wr_reg_src          = WR_CSR;
               wr_reg_en           = 1'b1;
               illegal_instruction = csr_addr_exception;
               pc_en               = 1'b1;
               state_d             = S_FETCH;
            end
         end
         S_MULDIV: begin
            muldiv_start = !start_q;
            alu_src      = funct3;
            aluy_src     = w_op;
            if (muldiv_done) begin
               wr_reg_src = WR_MUL;
               wr_reg_en  = 1'b1;
               pc_en      = 1'b1;
               state_d    = S_FETCH;
            end else begin
               start_d = 1'b1;
            end
         end
         S_ILLEGAL: begin
            illegal_instruction = 1'b1;
            pc_en               = 1'b1;
            state_d             = S_FETCH;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule
